// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath: steps the shared
// ALU and memory through fetch/decode/execute/memory/write-back and counts retirements.
module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic [1:0]       PCSource,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             MemtoReg,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      EXEC_I   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      ILLEGAL  = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LI    = 6'b100111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   state_t           state_reg, state_next;
   logic             illegal_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             retire_now;
   ctrl_t            ctrl_dec;

   // Next state; opcode is only looked at in DECODE and MEM_ADDR.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FETCH:    if (mem_ready) state_next = DECODE;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      state_next = EXEC_R;
               OP_ADDI, OP_LI: state_next = EXEC_I;
               OP_LW, OP_SW:  state_next = MEM_ADDR;
               OP_BEQ:        state_next = BRANCH;
               OP_J:          state_next = JUMP;
               default:       state_next = ILLEGAL;
            endcase
         end
         MEM_ADDR: begin
            if (opcode == OP_LW)
               state_next = MEM_RD;
            else if (opcode == OP_SW)
               state_next = MEM_WR;
            else
               state_next = ILLEGAL;
         end
         MEM_RD:   if (mem_ready) state_next = MEM_WB;
         MEM_WB:   state_next = FETCH;
         MEM_WR:   if (mem_ready) state_next = FETCH;
         EXEC_R:   state_next = R_WB;
         R_WB:     state_next = FETCH;
         EXEC_I:   state_next = I_WB;
         I_WB:     state_next = FETCH;
         BRANCH:   state_next = FETCH;
         JUMP:     state_next = FETCH;
         ILLEGAL:  state_next = ILLEGAL;
         default:  state_next = ILLEGAL;
      endcase
   end

   always_comb begin
      retire_now = 1'b0;
      case (state_reg)
         R_WB, I_WB, MEM_WB, BRANCH, JUMP: retire_now = 1'b1;
         MEM_WR:                           retire_now = mem_ready;
         default:                          retire_now = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= FETCH;
         illegal_reg <= 1'b0;
         retired_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_next == ILLEGAL)
            illegal_reg <= 1'b1;
         if (retire_now)
            retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   // Control decode from the current state; IRWrite/PCWrite in FETCH follow mem_ready.
   always_comb begin
      ctrl_dec = '0;
      case (state_reg)
         FETCH: begin
            ctrl_dec.mem_req   = 1'b1;
            ctrl_dec.mem_read  = 1'b1;
            ctrl_dec.alu_src_b = 2'b01;
            ctrl_dec.ir_write  = mem_ready;
            ctrl_dec.pc_write  = mem_ready;
         end
         DECODE: ctrl_dec.alu_src_b = 2'b11;
         EXEC_R: begin
            ctrl_dec.alu_src_a = 1'b1;
            ctrl_dec.alu_op    = 2'b10;
         end
         R_WB: begin
            ctrl_dec.reg_dst   = 1'b1;
            ctrl_dec.reg_write = 1'b1;
         end
         EXEC_I, MEM_ADDR: begin
            ctrl_dec.alu_src_a = 1'b1;
            ctrl_dec.alu_src_b = 2'b10;
         end
         I_WB: ctrl_dec.reg_write = 1'b1;
         MEM_RD: begin
            ctrl_dec.mem_req  = 1'b1;
            ctrl_dec.mem_read = 1'b1;
            ctrl_dec.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            ctrl_dec.reg_write  = 1'b1;
            ctrl_dec.mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            ctrl_dec.mem_req   = 1'b1;
            ctrl_dec.mem_write = 1'b1;
            ctrl_dec.i_or_d    = 1'b1;
         end
         BRANCH: begin
            ctrl_dec.alu_src_a     = 1'b1;
            ctrl_dec.alu_op        = 2'b01;
            ctrl_dec.pc_write_cond = 1'b1;
            ctrl_dec.pc_source     = 2'b01;
         end
         JUMP: begin
            ctrl_dec.pc_write  = 1'b1;
            ctrl_dec.pc_source = 2'b10;
         end
         default: ctrl_dec = '0;
      endcase
   end

   // While reset is held every control is gated off, even though state already reads FETCH.
   assign mem_req     = ctrl_dec.mem_req       & rst_n;
   assign MemRead     = ctrl_dec.mem_read      & rst_n;
   assign MemWrite    = ctrl_dec.mem_write     & rst_n;
   assign IorD        = ctrl_dec.i_or_d        & rst_n;
   assign IRWrite     = ctrl_dec.ir_write      & rst_n;
   assign PCWrite     = ctrl_dec.pc_write      & rst_n;
   assign PCWriteCond = ctrl_dec.pc_write_cond & rst_n;
   assign PCSource    = ctrl_dec.pc_source     & {2{rst_n}};
   assign ALUSrcA     = ctrl_dec.alu_src_a     & rst_n;
   assign ALUSrcB     = ctrl_dec.alu_src_b     & {2{rst_n}};
   assign ALUOp       = ctrl_dec.alu_op        & {2{rst_n}};
   assign RegDst      = ctrl_dec.reg_dst       & rst_n;
   assign RegWrite    = ctrl_dec.reg_write     & rst_n;
   assign MemtoReg    = ctrl_dec.mem_to_reg    & rst_n;

   assign illegal = illegal_reg;
   assign state   = state_reg;
   assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expected per-cycle state/control sequences are
// generated from each instruction's phase list and compared every cycle.
module tb_multicycle_control;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [5:0]       opcode;
   logic             mem_ready;
   logic             mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
   logic [1:0]       PCSource, ALUSrcB, ALUOp;
   logic             ALUSrcA, RegDst, RegWrite, MemtoReg, illegal;
   logic [3:0]       state;
   logic [CNT_W-1:0] retired;

   multicycle_control #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .illegal(illegal), .state(state), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [16:0] ctrl_obs;
   assign ctrl_obs = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                      PCSource, ALUSrcA, ALUSrcB, ALUOp, RegDst, RegWrite, MemtoReg};

   int n_checks = 0;
   int n_errors = 0;
   int model_retired = 0;
   bit model_illegal = 1'b0;
   int instr_cycles;

   logic [3:0] q_state[$];
   bit         q_ready[$];
   bit         q_retire[$];

   logic [5:0] legal_ops [7] = '{6'b000000, 6'b001000, 6'b100111, 6'b100011,
                                 6'b101011, 6'b000100, 6'b000010};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Control word required for a state, straight from the per-state output table.
   function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input bit rdy);
      logic req, mrd, mwr, iord, irw, pcw, pcwc, srca, rdst, rwr, m2r;
      logic [1:0] pcsrc, srcb, aop;
      {req, mrd, mwr, iord, irw, pcw, pcwc, srca, rdst, rwr, m2r} = '0;
      {pcsrc, srcb, aop} = '0;
      case (s)
         4'd0:  begin req = 1; mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
         4'd1:  srcb = 2'b11;
         4'd2:  begin srca = 1; srcb = 2'b10; end
         4'd3:  begin req = 1; mrd = 1; iord = 1; end
         4'd4:  begin rwr = 1; m2r = 1; end
         4'd5:  begin req = 1; mwr = 1; iord = 1; end
         4'd6:  begin srca = 1; aop = 2'b10; end
         4'd7:  begin rdst = 1; rwr = 1; end
         4'd8:  begin srca = 1; srcb = 2'b10; end
         4'd9:  rwr = 1;
         4'd10: begin srca = 1; aop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
         4'd11: begin pcw = 1; pcsrc = 2'b10; end
         default: ;
      endcase
      return {req, mrd, mwr, iord, irw, pcw, pcwc, pcsrc, srca, srcb, aop, rdst, rwr, m2r};
   endfunction

   task automatic push(input logic [3:0] s, input bit rdy, input bit ret);
      q_state.push_back(s);
      q_ready.push_back(rdy);
      q_retire.push_back(ret);
   endtask

   // Entered and left at a falling edge.
   task automatic step(input logic [3:0] es, input bit rdy, input bit ret, input logic [5:0] op);
      mem_ready = rdy;
      opcode = (es == 4'd0) ? 6'($urandom) : op;
      if (es == 4'd15) model_illegal = 1'b1;
      #1;
      check_eq("state",   32'(state),    32'(es));
      check_eq("ctrl",    32'(ctrl_obs), 32'(exp_ctrl(es, rdy)));
      check_eq("illegal", 32'(illegal),  32'(model_illegal));
      check_eq("retired", 32'(retired),  32'(model_retired));
      @(posedge clk);
      if (ret) model_retired = (model_retired + 1) % (1 << CNT_W);
      @(negedge clk);
   endtask

   // Builds the expected phase list for one instruction and plays it.
   // trunc_rd > 0 stops a lw after that many MEM_RD wait cycles (for reset tests).
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int trunc_rd);
      for (int i = 0; i < fw; i++) push(4'd0, 1'b0, 1'b0);
      push(4'd0, 1'b1, 1'b0);
      push(4'd1, 1'($urandom), 1'b0);
      case (op)
         6'b000000: begin push(4'd6, 1'($urandom), 0); push(4'd7, 1'($urandom), 1); end
         6'b001000, 6'b100111: begin push(4'd8, 1'($urandom), 0); push(4'd9, 1'($urandom), 1); end
         6'b100011: begin
            push(4'd2, 1'($urandom), 0);
            if (trunc_rd > 0) begin
               for (int i = 0; i < trunc_rd; i++) push(4'd3, 1'b0, 1'b0);
            end else begin
               for (int i = 0; i < mw; i++) push(4'd3, 1'b0, 1'b0);
               push(4'd3, 1'b1, 1'b0);
               push(4'd4, 1'($urandom), 1'b1);
            end
         end
         6'b101011: begin
            push(4'd2, 1'($urandom), 0);
            for (int i = 0; i < mw; i++) push(4'd5, 1'b0, 1'b0);
            push(4'd5, 1'b1, 1'b1);
         end
         6'b000100: push(4'd10, 1'($urandom), 1'b1);
         6'b000010: push(4'd11, 1'($urandom), 1'b1);
         default: for (int i = 0; i < 6; i++) push(4'd15, 1'($urandom), 1'b0);
      endcase
      instr_cycles = q_state.size();
      while (q_state.size() > 0)
         step(q_state.pop_front(), q_ready.pop_front(), q_retire.pop_front(), op);
      $display("instr op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d retired=%0d",
               op, fw, mw, instr_cycles, retired);
   endtask

   // Entered and left at a falling edge; checks the immediate effect of reset.
   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      model_retired = 0;
      model_illegal = 1'b0;
      check_eq("rst_ctrl",    32'(ctrl_obs), 32'd0);
      check_eq("rst_state",   32'(state),    32'd0);
      check_eq("rst_retired", 32'(retired),  32'd0);
      check_eq("rst_illegal", 32'(illegal),  32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released t=%0t", $time);
   endtask

   initial begin
      logic [5:0] op;
      bit is_legal;
      rst_n = 1'b0;
      mem_ready = 1'b0;
      opcode = 6'd0;
      @(negedge clk);
      do_reset();

      // Directed sequence from the test plan.
      run_instr(6'b100011, 0, 0, 0);
      run_instr(6'b101011, 0, 3, 0);
      run_instr(6'b000100, 0, 0, 0);
      run_instr(6'b000010, 0, 0, 0);
      run_instr(6'b000000, 0, 0, 0);
      run_instr(6'b001000, 0, 0, 0);
      run_instr(6'b100111, 0, 0, 0);

      // Randomized legal traffic (long enough to wrap the small counter).
      for (int n = 0; n < 120; n++)
         run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 0);

      // Reset in the middle of a load's memory wait.
      run_instr(6'b100011, $urandom_range(0, 1), 0, $urandom_range(1, 3));
      do_reset();
      for (int n = 0; n < 20; n++)
         run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 0);

      // Undefined opcodes lock up in ILLEGAL until reset.
      run_instr(6'b111111, 0, 0, 0);
      do_reset();
      for (int n = 0; n < 6; n++) begin
         do begin
            op = 6'($urandom);
            is_legal = 1'b0;
            foreach (legal_ops[k]) if (legal_ops[k] == op) is_legal = 1'b1;
         end while (is_legal);
         run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 0);
         run_instr(op, $urandom_range(0, 2), 0, 0);
         do_reset();
      end
      run_instr(6'b100011, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
